// File: rtl/md_sched.sv
// md_sched: multi-cycle multiply/divide scheduler for the E stage.
// Computes mult/div results at issue, holds them in pending registers,
// and commits HI/LO after a fixed latency while reporting busy.
`timescale 1ns/1ps
module md_sched #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam int unsigned DW      = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_p_hi;
  logic [DW-1:0]    r_p_lo;
  logic [DW-1:0]    r_hi;
  logic [DW-1:0]    r_lo;
  logic             r_busy;

  logic                 w_accept;
  logic signed [63:0]   w_a_sx;
  logic signed [63:0]   w_b_sx;
  logic signed [63:0]   w_prod_s;
  logic [63:0]          w_prod_u;
  logic signed [DW-1:0] w_a_s;
  logic signed [DW-1:0] w_b_s;
  logic signed [DW-1:0] w_quo_s;
  logic signed [DW-1:0] w_rem_s;
  logic [DW-1:0]        w_quo_u;
  logic [DW-1:0]        w_rem_u;
  logic                 w_div_zero;
  logic                 w_div_ovf;
  logic [DW-1:0]        w_res_hi;
  logic [DW-1:0]        w_res_lo;

  assign w_accept = start & ~cancel;

  // Operand views for the signed and unsigned datapaths
  assign w_a_sx   = {{32{src_a[31]}}, src_a};
  assign w_b_sx   = {{32{src_b[31]}}, src_b};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'd0, src_a} * {32'd0, src_b};
  assign w_a_s    = src_a;
  assign w_b_s    = src_b;

  assign w_div_zero = (src_b == 32'd0);
  assign w_div_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);

  // Quotient/remainder, guarded so zero and overflow cases never reach the dividers
  always_comb begin
    w_quo_s = '0;
    w_rem_s = '0;
    w_quo_u = '0;
    w_rem_u = '0;
    if (!w_div_zero && !w_div_ovf) begin
      w_quo_s = w_a_s / w_b_s;
      w_rem_s = w_a_s % w_b_s;
    end
    if (!w_div_zero) begin
      w_quo_u = src_a / src_b;
      w_rem_u = src_a % src_b;
    end
  end

  // Full result selected at issue; divide by zero preserves committed HI/LO
  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (op)
      OP_MULT: begin
        w_res_hi = w_prod_s[63:32];
        w_res_lo = w_prod_s[31:0];
      end
      OP_MULTU: begin
        w_res_hi = w_prod_u[63:32];
        w_res_lo = w_prod_u[31:0];
      end
      OP_DIV: begin
        if (w_div_ovf) begin
          w_res_hi = 32'd0;
          w_res_lo = 32'h8000_0000;
        end else if (!w_div_zero) begin
          w_res_hi = w_rem_s;
          w_res_lo = w_quo_s;
        end
      end
      OP_DIVU: begin
        if (!w_div_zero) begin
          w_res_hi = w_rem_u;
          w_res_lo = w_quo_u;
        end
      end
      default: begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
      end
    endcase
  end

  // Scheduler FSM: issue in IDLE, count down in RUN, commit on the last count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_p_hi  <= '0;
      r_p_lo  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                r_p_hi  <= w_res_hi;
                r_p_lo  <= w_res_lo;
                r_cnt   <= CNT_W'(MULT_LAT);
                r_state <= S_RUN;
                r_busy  <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                r_p_hi  <= w_res_hi;
                r_p_lo  <= w_res_lo;
                r_cnt   <= CNT_W'(DIV_LAT);
                r_state <= S_RUN;
                r_busy  <= 1'b1;
              end
              OP_MTHI: r_hi <= src_a;
              OP_MTLO: r_lo <= src_a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_hi    <= r_p_hi;
            r_lo    <= r_p_lo;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign hi    = r_hi;
  assign lo    = r_lo;
  // Move-from path reads committed registers only
  assign rdata = (op == OP_MFHI) ? r_hi : r_lo;

endmodule

// File: doc/md_sched.md
# md_sched

Multi-cycle multiply/divide scheduler sitting in the E stage beside the ALU. Accepts mult/div/move-to-HI/LO issues from the E-stage control decode, computes and commits HI/LO after a fixed, parameterised latency, and reports `busy` so the hazard unit can stall MD-class instructions in D. Issues squashed by an exception/interrupt request in the same cycle are dropped.

## Interface

- `MULT_LAT`, 5, cycles of busy for mult/multu (>=1)
- `DIV_LAT`, 10, cycles of busy for div/divu (>=1)

- `clk`  input  1  single clock; all state on rising edge
- `reset`  input  1  asynchronous, active-low; clears all state immediately
- `start`  input  1  issue strobe from E stage, one cycle per instruction
- `op`  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo
- `src_a`  input  32  rs operand (forwarded)
- `src_b`  input  32  rt operand (forwarded)
- `cancel`  input  1  exception/interrupt request; suppresses a same-cycle issue
- `busy`  output  1  operation in flight
- `hi`  output  32  committed HI register
- `lo`  output  32  committed LO register
- `rdata`  output  32  `op`==6 ? `hi` : `lo` (combinational, mf path)

## Operation

- States: IDLE, RUN. Counter `cnt` sized to max(MULT_LAT, DIV_LAT).
- Accepted issue = `start` & !`cancel` & state==IDLE. All other `start` pulses ignored; no state change.
- IDLE, accepted op 0-3: compute full result from `src_a`/`src_b` at issue into pending regs `p_hi`/`p_lo`; load `cnt` with MULT_LAT (op 0,1) or DIV_LAT (op 2,3); -> RUN.
- IDLE, accepted op 4: `hi` <= `src_a` next edge; stays IDLE. Op 5: `lo` <= `src_a`. Ops 6,7: no state effect.
- RUN: `cnt` decrements each edge; on the edge where `cnt`==1: `hi`<=`p_hi`, `lo`<=`p_lo`, -> IDLE.
- mult: signed 32x32 -> 64; `hi` = [63:32], `lo` = [31:0]. multu: unsigned.
- div: signed; `lo` = quotient truncated toward zero, `hi` = remainder, sign of dividend. divu: unsigned.
- Divide by zero (`src_b`==0, op 2/3): timing unchanged, HI/LO left unchanged at commit (pending regs loaded with current hi/lo).
- div 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- `cancel` while RUN: no effect; in-flight op completes (it was issued before the exception).
- `busy` = (state==RUN). `hi`/`lo` never change while RUN except at commit edge.

## Timing

- Reset (`reset`=0): state IDLE, `cnt`=0, `busy`=0, `hi`=0, `lo`=0, pending regs 0; asynchronous, takes effect without clock. Reset mid-RUN aborts, no commit.
- Issue sampled at edge T: `busy`=1 in cycles T+1 .. T+LAT; new HI/LO visible from cycle T+LAT+1, same cycle `busy` drops to 0.
- Back-to-back: a `start` in cycle T+LAT+1 (busy low) is accepted; a `start` during busy is ignored.
- mthi/mtlo: visible in `hi`/`lo` the cycle after issue; `busy` stays 0.
- `rdata` reflects committed registers only; no bypass of pending values.

## Test plan

- Reset, then mult with `src_a`=0xFFFFFFFF, `src_b`=2 -> `busy` high exactly 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE; repeat as multu -> `hi`=0x00000001, `lo`=0xFFFFFFFE.
- div `src_a`=0xFFFFFFF9 (-7), `src_b`=2 -> `busy` 10 cycles, `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; divu 7/2 -> `lo`=3, `hi`=1.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 on consecutive cycles -> `hi`/`lo` updated next cycle each, `busy` never asserts; op 6 `rdata`=0x12345678, op 7 `rdata`=0x9ABCDEF0.
- `start`+`cancel` same cycle with mult 3x4 -> `busy` stays 0, HI/LO unchanged; `cancel` pulsed during a RUN mult 3x4 -> commits `lo`=12, `hi`=0.
- divu by zero with prior `hi`=0xAA, `lo`=0xBB -> busy 10 cycles, then `hi`=0xAA, `lo`=0xBB; `start` asserted mid-busy with mult is ignored (no second busy period).
- Assert `reset` low in 3rd busy cycle of a div -> `busy`, `hi`, `lo` go 0 immediately and remain 0 after release; next issued op behaves normally.
